// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle widths, bit positions and NOP encodings.
package pipe_pkg;

  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  // EX bundle {RegDst, ALUOp[1:0], ALUSrc}
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  // M bundle {Branch, MemRead, MemWrite}
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // WB bundle {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [EX_W-1:0] EX_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [WB_W-1:0] WB_NOP = '0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctl_t;

  localparam ctl_t CTL_NOP = '{ex: EX_NOP, m: M_NOP, wb: WB_NOP};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the instruction in ID.
module hazard_detect #(
  parameter int RADDR = 5
) (
  input  logic             ex_memread,
  input  logic             ex_valid,
  input  logic [RADDR-1:0] ex_rt,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  output logic             hz
);

  // $zero never carries a real dependency.
  assign hz = ex_memread & ex_valid & (ex_rt != '0) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, freeze and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int RADDR  = 5,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [EX_W-1:0]   id_ex_ctl,
  input  logic [M_W-1:0]    id_m_ctl,
  input  logic [WB_W-1:0]   id_wb_ctl,
  input  logic [DWIDTH-1:0] id_npc,
  input  logic [DWIDTH-1:0] id_rd1,
  input  logic [DWIDTH-1:0] id_rd2,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [RADDR-1:0]  id_rs,
  input  logic [RADDR-1:0]  id_rt,
  input  logic [RADDR-1:0]  id_rd,
  input  logic              flush,
  input  logic              freeze,
  output logic [EX_W-1:0]   ex_ctl,
  output logic [M_W-1:0]    m_ctl,
  output logic [WB_W-1:0]   wb_ctl,
  output logic [DWIDTH-1:0] ex_npc,
  output logic [DWIDTH-1:0] ex_rd1,
  output logic [DWIDTH-1:0] ex_rd2,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [RADDR-1:0]  ex_rs,
  output logic [RADDR-1:0]  ex_rt,
  output logic [RADDR-1:0]  ex_rd,
  output logic              ex_valid,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNTW-1:0]   bubble_cnt
);

  ctl_t            ctl_q;
  logic            hz;
  logic [CNTW-1:0] cnt_next;

  hazard_detect #(.RADDR(RADDR)) u_hazard (
    .ex_memread (ctl_q.m[M_MEMREAD]),
    .ex_valid   (ex_valid),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hz         (hz)
  );

  // Stall contract: pc_write/ifid_write low means upstream must hold PC and IF/ID
  // this cycle; the same id_* values are expected again on the next cycle.
  assign pc_write   = ~(hz | freeze);
  assign ifid_write = ~(hz | freeze);

  assign cnt_next = (&bubble_cnt) ? bubble_cnt : bubble_cnt + CNTW'(1);

  assign ex_ctl = ctl_q.ex;
  assign m_ctl  = ctl_q.m;
  assign wb_ctl = ctl_q.wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q      <= CTL_NOP;
      ex_npc     <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush || (!freeze && hz)) begin
      // Squash wins over freeze; datapath fields load but are meaningless in a bubble.
      ctl_q      <= CTL_NOP;
      ex_npc     <= id_npc;
      ex_rd1     <= id_rd1;
      ex_rd2     <= id_rd2;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_valid   <= 1'b0;
      bubble_cnt <= cnt_next;
    end else if (!freeze) begin
      ctl_q      <= '{ex: id_ex_ctl, m: id_m_ctl, wb: id_wb_ctl};
      ex_npc     <= id_npc;
      ex_rd1     <= id_rd1;
      ex_rd2     <= id_rd2;
      ex_imm     <= id_imm;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage (CNTW=4) with an expected-output queue.
module tb_id_ex_stage;

  localparam int EW = 158;
  localparam logic [1:0] K_LOAD = 2'd0, K_BUB = 2'd1, K_HOLD = 2'd2;

  localparam logic [3:0] EX_LW = 4'b0001, EX_R = 4'b1100, EX_SW = 4'b0001, EX_BEQ = 4'b0010;
  localparam logic [2:0] M_LW  = 3'b010,  M_R  = 3'b000,  M_SW  = 3'b001,  M_BEQ  = 3'b100;
  localparam logic [1:0] WB_LW = 2'b11,   WB_R = 2'b10,   WB_SW = 2'b00,   WB_BEQ = 2'b00;

  typedef struct {
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] npc;
    logic [4:0]  rs, rt, rd;
    logic        fl, fr;
    logic [1:0]  kind;
    logic        pcw;
    logic [3:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_ex_ctl;
  logic [2:0]  id_m_ctl;
  logic [1:0]  id_wb_ctl;
  logic [31:0] id_npc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        flush, freeze;
  logic [3:0]  ex_ctl;
  logic [2:0]  m_ctl;
  logic [1:0]  wb_ctl;
  logic [31:0] ex_npc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_valid, pc_write, ifid_write;
  logic [3:0]  bubble_cnt;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp;
  int total = 0;
  int bad = 0;
  vec_t tbl[21];

  id_ex_stage #(.DWIDTH(32), .RADDR(5), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .id_ex_ctl(id_ex_ctl), .id_m_ctl(id_m_ctl), .id_wb_ctl(id_wb_ctl),
    .id_npc(id_npc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .freeze(freeze),
    .ex_ctl(ex_ctl), .m_ctl(m_ctl), .wb_ctl(wb_ctl),
    .ex_npc(ex_npc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .pc_write(pc_write), .ifid_write(ifid_write),
    .bubble_cnt(bubble_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic vec_t row(logic [3:0] ex, logic [2:0] m, logic [1:0] wb, logic [31:0] npc,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic fl, logic fr,
                               logic [1:0] kind, logic pcw, logic [3:0] cnt);
    vec_t v;
    v.ex = ex; v.m = m; v.wb = wb; v.npc = npc; v.rs = rs; v.rt = rt; v.rd = rd;
    v.fl = fl; v.fr = fr; v.kind = kind; v.pcw = pcw; v.cnt = cnt;
    return v;
  endfunction

  // Datapath operands are derived from npc so every field carries a distinct value.
  function automatic logic [EW-1:0] mk_load(vec_t v);
    return {1'b1, v.ex, v.m, v.wb, 1'b1, v.cnt, v.rs, v.rt, v.rd,
            v.npc, v.npc + 32'h11, v.npc + 32'h22, v.npc + 32'h33};
  endfunction

  function automatic logic [EW-2:0] act_word();
    return {ex_ctl, m_ctl, wb_ctl, ex_valid, bubble_cnt, ex_rs, ex_rt, ex_rd,
            ex_npc, ex_rd1, ex_rd2, ex_imm};
  endfunction

  task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    id_ex_ctl = v.ex; id_m_ctl = v.m; id_wb_ctl = v.wb;
    id_npc = v.npc; id_rd1 = v.npc + 32'h11; id_rd2 = v.npc + 32'h22; id_imm = v.npc + 32'h33;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    flush = v.fl; freeze = v.fr;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_out(input string name, input int idx);
    logic [EW-1:0] e;
    logic [EW-2:0] a;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s idx=%0d expected queue empty", name, idx);
      return;
    end
    e = exp_q.pop_front();
    a = act_word();
    // Bubbles only pin down controls, valid and the counter.
    if (e[EW-1] ? (a !== e[EW-2:0]) : (a[156:143] !== e[156:143])) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h want=%h", name, idx, a, e[EW-2:0]);
    end
  endtask

  task automatic apply(input string name, input int idx, input vec_t v);
    logic [EW-1:0] e;
    @(negedge clk);
    drive(v);
    #1;
    check_bit({name, "_pc_write"}, idx, pc_write, v.pcw);
    check_bit({name, "_ifid_write"}, idx, ifid_write, v.pcw);
    case (v.kind)
      K_LOAD:  e = mk_load(v);
      K_BUB:   e = {1'b0, 9'd0, 1'b0, v.cnt, 143'd0};
      default: e = {last_exp[EW-1:147], v.cnt, last_exp[142:0]};
    endcase
    exp_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    compare_out(name, idx);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int ec;

    // T1..T5 and mixed cases; cnt/pcw hand-derived from the stage's rules.
    tbl[0]  = row(EX_LW,  M_LW,  WB_LW,  32'h100, 5'd1,  5'd8,  5'd0, 0, 0, K_LOAD, 1, 4'd0);
    tbl[1]  = row(EX_R,   M_R,   WB_R,   32'h104, 5'd8,  5'd2,  5'd3, 0, 0, K_BUB,  0, 4'd1);
    tbl[2]  = row(EX_R,   M_R,   WB_R,   32'h104, 5'd8,  5'd2,  5'd3, 0, 0, K_LOAD, 1, 4'd1);
    tbl[3]  = row(EX_LW,  M_LW,  WB_LW,  32'h108, 5'd4,  5'd0,  5'd0, 0, 0, K_LOAD, 1, 4'd1);
    tbl[4]  = row(EX_R,   M_R,   WB_R,   32'h10c, 5'd0,  5'd0,  5'd5, 0, 0, K_LOAD, 1, 4'd1);
    tbl[5]  = row(EX_LW,  M_LW,  WB_LW,  32'h110, 5'd2,  5'd9,  5'd0, 0, 0, K_LOAD, 1, 4'd1);
    tbl[6]  = row(EX_SW,  M_SW,  WB_SW,  32'h114, 5'd3,  5'd9,  5'd0, 0, 0, K_BUB,  0, 4'd2);
    tbl[7]  = row(EX_SW,  M_SW,  WB_SW,  32'h114, 5'd3,  5'd9,  5'd0, 0, 0, K_LOAD, 1, 4'd2);
    tbl[8]  = row(EX_LW,  M_LW,  WB_LW,  32'h118, 5'd1,  5'd10, 5'd0, 0, 0, K_LOAD, 1, 4'd2);
    tbl[9]  = row(EX_R,   M_R,   WB_R,   32'h11c, 5'd10, 5'd4,  5'd6, 1, 0, K_BUB,  0, 4'd3);
    tbl[10] = row(EX_R,   M_R,   WB_R,   32'h200, 5'd10, 5'd4,  5'd6, 0, 0, K_LOAD, 1, 4'd3);
    tbl[11] = row(EX_LW,  M_LW,  WB_LW,  32'h204, 5'd11, 5'd12, 5'd1, 0, 1, K_HOLD, 0, 4'd3);
    tbl[12] = row(EX_BEQ, M_BEQ, WB_BEQ, 32'h208, 5'd13, 5'd14, 5'd2, 0, 1, K_HOLD, 0, 4'd3);
    tbl[13] = row(EX_SW,  M_SW,  WB_SW,  32'h20c, 5'd15, 5'd16, 5'd3, 0, 1, K_HOLD, 0, 4'd3);
    tbl[14] = row(EX_R,   M_R,   WB_R,   32'h210, 5'd17, 5'd18, 5'd4, 1, 1, K_BUB,  0, 4'd4);
    tbl[15] = row(EX_BEQ, M_BEQ, WB_BEQ, 32'h214, 5'd1,  5'd2,  5'd0, 0, 0, K_LOAD, 1, 4'd4);
    tbl[16] = row(EX_LW,  M_LW,  WB_LW,  32'h218, 5'd1,  5'd7,  5'd0, 1, 0, K_BUB,  1, 4'd5);
    tbl[17] = row(EX_LW,  M_LW,  WB_LW,  32'h300, 5'd1,  5'd7,  5'd0, 0, 0, K_LOAD, 1, 4'd5);
    tbl[18] = row(EX_R,   M_R,   WB_R,   32'h304, 5'd7,  5'd3,  5'd9, 0, 1, K_HOLD, 0, 4'd5);
    tbl[19] = row(EX_R,   M_R,   WB_R,   32'h304, 5'd7,  5'd3,  5'd9, 0, 0, K_BUB,  0, 4'd6);
    tbl[20] = row(EX_R,   M_R,   WB_R,   32'h304, 5'd7,  5'd3,  5'd9, 0, 0, K_LOAD, 1, 4'd6);

    // Reset with all inputs idle.
    rst = 1'b1;
    drive(row(4'd0, 3'd0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, K_LOAD, 1, 4'd0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.push_back({1'b1, 157'd0});
    compare_out("reset_state", 0);
    check_bit("reset_pc_write", 0, pc_write, 1'b1);
    last_exp = {1'b1, 157'd0};

    for (int i = 0; i < 21; i++) apply("row", i, tbl[i]);

    // Saturation: 20 consecutive flush bubbles from a count of 6 stick at 15.
    ec = 6;
    for (int i = 0; i < 20; i++) begin
      ec = (ec < 15) ? ec + 1 : 15;
      v = row(EX_R, M_R, WB_R, 32'h400 + 32'(i * 4), 5'd1, 5'd2, 5'd3, 1, 0, K_BUB, 1, 4'(ec));
      apply("sat", i, v);
    end

    // Reset arriving during a load-use stall.
    apply("pre_stall_lw", 0, row(EX_LW, M_LW, WB_LW, 32'h500, 5'd1, 5'd8, 5'd0, 0, 0, K_LOAD, 1, 4'd15));
    @(negedge clk);
    drive(row(EX_R, M_R, WB_R, 32'h504, 5'd8, 5'd2, 5'd3, 0, 0, K_BUB, 0, 4'd0));
    rst = 1'b1;
    #1;
    check_bit("stall_pc_write", 0, pc_write, 1'b0);
    exp_q.push_back({1'b1, 157'd0});
    @(posedge clk);
    #1;
    compare_out("rst_mid_stall", 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_bit("post_rst_pc_write", 0, pc_write, 1'b1);
    check_bit("post_rst_ifid_write", 0, ifid_write, 1'b1);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain leftover=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
